// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, feeder FSM states and lane slicing helper for the skew feeder.
package systolic_pkg;
    localparam int DEF_LANES = 5;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feeder_state_t;
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/skew_lane.sv
// skew_lane: DEPTH-stage valid+data shift chain; bubbles enter as zero data so they never pollute accumulation.
module skew_lane #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (ena) begin
            vld_d[0] = in_valid;
            dat_d[0] = in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = dat_q[i-1];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: skews each accepted lane vector into a diagonal wavefront and drains the tile without bubbles.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_TILE = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic               in_last,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]   out_lane_valid,
    output logic               tile_done,
    output logic               overrun
);
    localparam int BW = $clog2(MAX_TILE + 1);
    localparam int DW = (LANES > 2) ? $clog2(LANES - 1) : 1;

    feeder_state_t state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          overrun_q, overrun_d, tile_done_q, tile_done_d;
    logic          accept;

    assign in_ready = ena && !rst && state_q != DRAIN;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        drain_d     = drain_q;
        overrun_d   = overrun_q;
        tile_done_d = ena ? 1'b0 : tile_done_q;
        if (ena && state_q == DRAIN) begin
            drain_d = drain_q + 1'b1;
            if (drain_q == DW'(LANES - 2)) begin
                state_d     = IDLE;
                beat_d      = '0;
                drain_d     = '0;
                tile_done_d = 1'b1;
            end
        end else if (accept) begin
            beat_d  = beat_q + 1'b1;
            state_d = STREAM;
            // A last that lands exactly on MAX_TILE is a clean end, not an overrun.
            if (in_last || beat_d == BW'(MAX_TILE)) begin
                state_d   = DRAIN;
                drain_d   = '0;
                overrun_d = overrun_q | !in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            drain_q     <= '0;
            overrun_q   <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            drain_q     <= drain_d;
            overrun_q   <= overrun_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign tile_done = tile_done_q;
    assign overrun   = overrun_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        skew_lane #(.DEPTH(k + 1), .WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .in_valid (accept),
            .in_data  (in_data[lane_lo(k, WIDTH) +: WIDTH]),
            .out_valid(out_lane_valid[k]),
            .out_data (out_data[lane_lo(k, WIDTH) +: WIDTH])
        );
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed tiles against a per-lane delay-queue scoreboard and a handshake/drain model.
module tb_systolic_skew_feeder;
    import systolic_pkg::*;
    localparam int L  = DEF_LANES;
    localparam int W  = DEF_WIDTH;
    localparam int MT = 4;
    typedef struct packed { logic v; logic [W-1:0] d; } ent_t;

    logic           clk = 1'b0;
    logic           rst, ena, in_valid, in_ready, in_last, tile_done, overrun;
    logic [L*W-1:0] in_data, out_data;
    logic [L-1:0]   out_lane_valid;

    int   errors = 0;
    int   checks = 0;
    ent_t q[L][$];
    logic [L*W-1:0] exp_data;
    logic [L-1:0]   exp_valid;
    logic           exp_done, exp_ovr;
    int             drain_left, beat;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.LANES(L), .WIDTH(W), .MAX_TILE(MT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_data      (out_data),
        .out_lane_valid(out_lane_valid),
        .tile_done     (tile_done),
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L*W-1:0] vec(input logic [W-1:0] base);
        vec = '0;
        for (int k = 0; k < L; k++) vec[k*W +: W] = base + W'(k + 1);
    endfunction

    task automatic check_outputs();
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("out_lane_valid", 64'(out_lane_valid), 64'(exp_valid));
        chk("tile_done", 64'(tile_done), 64'(exp_done));
        chk("overrun", 64'(overrun), 64'(exp_ovr));
    endtask

    task automatic do_reset();
        ent_t z;
        z = '0;
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #1 chk("in_ready_in_reset", 64'(in_ready), 64'(0));
        exp_data = '0; exp_valid = '0; exp_done = 1'b0; exp_ovr = 1'b0;
        drain_left = 0; beat = 0;
        for (int k = 0; k < L; k++) begin
            q[k].delete();
            repeat (k) q[k].push_back(z);
        end
        repeat (2) begin
            @(posedge clk); #1;
            check_outputs();
        end
        rst = 1'b0;
    endtask

    task automatic step(input logic v, input logic [L*W-1:0] d, input logic l, input logic e);
        logic exp_ready, acc;
        ent_t ent;
        in_valid = v; in_data = d; in_last = l; ena = e;
        exp_ready = e && drain_left == 0;
        acc = v && exp_ready;
        #1 chk("in_ready", 64'(in_ready), 64'(exp_ready));
        @(posedge clk); #1;
        if (e) begin
            exp_done = drain_left == 1;
            if (drain_left > 0) drain_left--;
            else if (acc) begin
                beat++;
                if (l || beat == MT) begin
                    exp_ovr = exp_ovr | !l;
                    drain_left = L - 1;
                    beat = 0;
                end
            end
            for (int k = 0; k < L; k++) begin
                ent.v = acc;
                ent.d = acc ? d[k*W +: W] : '0;
                q[k].push_back(ent);
                ent = q[k].pop_front();
                exp_valid[k] = ent.v;
                exp_data[k*W +: W] = ent.d;
            end
        end
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        idle(3);
        // Three-vector tile; upstream keeps offering during drain and must be refused.
        step(1, vec(8'h10), 0, 1);
        step(1, vec(8'h20), 0, 1);
        step(1, vec(8'h30), 1, 1);
        repeat (4) step(1, vec(8'hE0), 0, 1);
        idle(3);
        // Upstream gap of two cycles mid-tile.
        step(1, vec(8'h40), 0, 1);
        idle(2);
        step(1, vec(8'h50), 0, 1);
        step(1, vec(8'h60), 1, 1);
        idle(6);
        // Enable toggling while streaming.
        step(1, vec(8'h70), 0, 1);
        step(1, vec(8'h80), 0, 0);
        step(1, vec(8'h80), 0, 1);
        step(1, vec(8'h90), 0, 0);
        step(1, vec(8'h90), 1, 1);
        step(0, '0, 0, 0);
        idle(6);
        // Last coinciding with MAX_TILE is a normal end.
        step(1, vec(8'hA0), 0, 1);
        step(1, vec(8'hB0), 0, 1);
        step(1, vec(8'hC0), 0, 1);
        step(1, vec(8'hD0), 1, 1);
        idle(6);
        // Overrun: MAX_TILE accepts without last.
        step(1, vec(8'h00), 0, 1);
        step(1, vec(8'h08), 0, 1);
        step(1, vec(8'h18), 0, 1);
        step(1, vec(8'h28), 0, 1);
        repeat (4) step(1, vec(8'h38), 0, 1);
        idle(2);
        step(1, vec(8'h48), 0, 1);
        step(1, vec(8'h58), 1, 1);
        idle(6);
        // Reset while draining: no tile_done, everything cleared.
        step(1, vec(8'h68), 1, 1);
        idle(3);
        do_reset();
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
